// File: rtl/imm_decode_stage_if.sv
// Handshake and result bus of the registered immediate decode stage.
// Both sides use valid/ready: a transfer happens on a rising clock edge where valid and ready are both high;
// once valid is raised, the payload is held stable until that transfer happens.
interface imm_decode_stage_if #(
  parameter int XLEN      = 32,
  parameter int CNT_WIDTH = 16
);
  logic                 flush_i;
  logic                 valid_i;
  logic                 ready_o;
  logic [31:0]          instr_i;
  logic                 valid_o;
  logic                 ready_i;
  logic [31:0]          instr_o;
  logic [XLEN-1:0]      imm_o;
  logic [2:0]           fmt_o;
  logic                 illegal_o;
  logic [CNT_WIDTH-1:0] count_o;

  modport master (
    output flush_i, valid_i, instr_i, ready_i,
    input  ready_o, valid_o, instr_o, imm_o, fmt_o, illegal_o, count_o
  );

  modport slave (
    input  flush_i, valid_i, instr_i, ready_i,
    output ready_o, valid_o, instr_o, imm_o, fmt_o, illegal_o, count_o
  );
endinterface

// File: rtl/imm_decode_stage.sv
// Registered RISC-V immediate decoder with a 2-entry skid buffer.
// Main register M drives the outputs; skid register K catches one entry under backpressure.
module imm_decode_stage #(
  parameter int XLEN      = 32,
  parameter int CNT_WIDTH = 16
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  imm_decode_stage_if.slave  bus,
  output logic [1:0]         state_o
);
  typedef enum logic [1:0] {S_EMPTY = 2'd0, S_ONE = 2'd1, S_FULL = 2'd2} state_t;

  localparam logic [2:0] FMT_R = 3'd0, FMT_I = 3'd1, FMT_S = 3'd2, FMT_B = 3'd3;
  localparam logic [2:0] FMT_U = 3'd4, FMT_J = 3'd5, FMT_Z = 3'd6, FMT_ILL = 3'd7;

  state_t               state_q, state_d;
  logic                 load_m, load_k, m_from_k;
  logic                 accept, ohs;
  logic [31:0]          ins;
  logic [XLEN-1:0]      dec_imm;
  logic [2:0]           dec_fmt;
  logic [31:0]          m_instr, k_instr;
  logic [XLEN-1:0]      m_imm, k_imm;
  logic [2:0]           m_fmt, k_fmt;
  logic [CNT_WIDTH-1:0] count_q;

  assign ins = bus.instr_i;

  always_comb begin
    dec_fmt = FMT_ILL;
    dec_imm = '0;
    case (ins[6:0])
      7'b0000011, 7'b0010011, 7'b1100111, 7'b0001111: begin
        dec_fmt = FMT_I;
        dec_imm = XLEN'($signed(ins[31:20]));
      end
      7'b0100011: begin
        dec_fmt = FMT_S;
        dec_imm = XLEN'($signed({ins[31:25], ins[11:7]}));
      end
      7'b1100011: begin
        dec_fmt = FMT_B;
        dec_imm = XLEN'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
      end
      7'b0110111, 7'b0010111: begin
        dec_fmt = FMT_U;
        dec_imm = XLEN'($signed({ins[31:12], 12'b0}));
      end
      7'b1101111: begin
        dec_fmt = FMT_J;
        dec_imm = XLEN'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
      end
      7'b0110011: dec_fmt = FMT_R;
      7'b1110011: begin
        case (ins[14:12])
          3'b000:                 dec_fmt = FMT_R;
          3'b001, 3'b010, 3'b011: begin
            dec_fmt = FMT_I;
            dec_imm = XLEN'(ins[31:20]);
          end
          3'b101, 3'b110, 3'b111: begin
            dec_fmt = FMT_Z;
            dec_imm = XLEN'(ins[19:15]);
          end
          default:                dec_fmt = FMT_ILL;
        endcase
      end
      // RV64-only word ops are undecodable on a 32-bit datapath
      7'b0011011: begin
        if (XLEN == 64) begin
          dec_fmt = FMT_I;
          dec_imm = XLEN'($signed(ins[31:20]));
        end
      end
      7'b0111011: begin
        if (XLEN == 64) dec_fmt = FMT_R;
      end
      default: dec_fmt = FMT_ILL;
    endcase
  end

  assign bus.ready_o = (state_q != S_FULL);
  assign bus.valid_o = (state_q != S_EMPTY);
  assign accept      = bus.valid_i & bus.ready_o;
  assign ohs         = bus.valid_o & bus.ready_i;

  always_comb begin
    state_d  = state_q;
    load_m   = 1'b0;
    load_k   = 1'b0;
    m_from_k = 1'b0;
    case (state_q)
      S_EMPTY: if (accept) begin
        load_m  = 1'b1;
        state_d = S_ONE;
      end
      S_ONE: begin
        if (accept && !ohs) begin
          load_k  = 1'b1;
          state_d = S_FULL;
        end else if (accept && ohs) begin
          load_m = 1'b1;
        end else if (ohs) begin
          state_d = S_EMPTY;
        end
      end
      S_FULL: if (ohs) begin
        m_from_k = 1'b1;
        state_d  = S_ONE;
      end
      default: state_d = S_EMPTY;
    endcase
    // Flush drops the buffered entries and any entry accepted this cycle
    if (bus.flush_i) begin
      state_d  = S_EMPTY;
      load_m   = 1'b0;
      load_k   = 1'b0;
      m_from_k = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_EMPTY;
      m_instr <= '0;
      m_imm   <= '0;
      m_fmt   <= FMT_R;
      k_instr <= '0;
      k_imm   <= '0;
      k_fmt   <= FMT_R;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      if (load_m) begin
        m_instr <= ins;
        m_imm   <= dec_imm;
        m_fmt   <= dec_fmt;
      end else if (m_from_k) begin
        m_instr <= k_instr;
        m_imm   <= k_imm;
        m_fmt   <= k_fmt;
      end
      if (load_k) begin
        k_instr <= ins;
        k_imm   <= dec_imm;
        k_fmt   <= dec_fmt;
      end
      if (ohs) count_q <= count_q + CNT_WIDTH'(1);
    end
  end

  assign bus.instr_o   = m_instr;
  assign bus.imm_o     = m_imm;
  assign bus.fmt_o     = m_fmt;
  assign bus.illegal_o = (m_fmt == FMT_ILL);
  assign bus.count_o   = count_q;
  assign state_o       = state_q;
endmodule
